// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush and
// data-memory wait freeze, with event counters and a memory-wait watchdog.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_inst,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_write,
  output logic        idex_bubble,
  output logic        exmem_hold,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        mem_timeout
);
  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic        r_timeout;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_hazard_lu;
  logic        w_freeze;
  logic        w_do_flush;
  logic        w_do_stall;

  assign w_opcode = id_inst[6:0];
  assign w_rs1    = id_inst[19:15];
  assign w_rs2    = id_inst[24:20];

  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      7'b0000011, 7'b0010011: w_use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign w_freeze    = dmem_req & ~dmem_ready;
  assign w_hazard_lu = (r_state == RUN) & ex_mem_read & (ex_rd != 5'd0) &
                       ((w_use_rs1 & (ex_rd == w_rs1)) | (w_use_rs2 & (ex_rd == w_rs2)));
  // A branch seen during a freeze is ignored; EX re-presents it on release.
  assign w_do_flush  = ~rst & ~w_freeze & ex_branch_taken;
  assign w_do_stall  = ~rst & ~w_freeze & ~ex_branch_taken & w_hazard_lu;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      exmem_hold = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_hazard_lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= 8'd0;
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_do_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_do_flush && r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
      case (r_state)
        RUN: begin
          if (w_freeze) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= 8'd0;
          end else if (w_do_stall) begin
            r_state <= LU_STALL;
          end
        end
        LU_STALL: begin
          if (w_freeze) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= 8'd0;
          end else begin
            r_state <= RUN;
          end
        end
        MEM_WAIT: begin
          if (r_wait_cnt != 8'hFF) r_wait_cnt <= r_wait_cnt + 8'd1;
          // Flag lands in the same cycle the counter shows 255.
          if (w_freeze && r_wait_cnt == 8'hFE) r_timeout <= 1'b1;
          if (!w_freeze) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign mem_timeout = r_timeout;
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port id_inst, input, 32 bits: instruction currently in the ID stage.
REQ-004 SHALL have port ex_mem_read, input, 1 bit: the instruction in EX is a load.
REQ-005 SHALL have port ex_rd, input, 5 bits: destination register of the instruction in EX.
REQ-006 SHALL have port ex_branch_taken, input, 1 bit: a branch resolved in EX is taken this cycle.
REQ-007 SHALL have port dmem_req, input, 1 bit: the MEM stage is issuing a data-memory access.
REQ-008 SHALL have port dmem_ready, input, 1 bit: data memory completes the access this cycle.
REQ-009 SHALL have port pc_write, output, 1 bit: PC update enable.
REQ-010 SHALL have port ifid_write, output, 1 bit: IF/ID register load enable.
REQ-011 SHALL have port ifid_flush, output, 1 bit: clear IF/ID to a NOP.
REQ-012 SHALL have port idex_write, output, 1 bit: ID/EX register load enable.
REQ-013 SHALL have port idex_bubble, output, 1 bit: load a NOP into ID/EX instead of the ID contents.
REQ-014 SHALL have port exmem_hold, output, 1 bit: freeze EX/MEM and MEM/WB.
REQ-015 SHALL have port stall_cnt, output, 16 bits: load-use stall cycle count.
REQ-016 SHALL have port flush_cnt, output, 16 bits: branch flush event count.
REQ-017 SHALL have port mem_timeout, output, 1 bit: sticky memory-wait watchdog flag.

Function
REQ-018 SHALL decode register usage from id_inst[6:0]:
- 0110011, 0100011, 1100011: rs1 and rs2 used.
- 0000011, 0010011: rs1 only.
- any other opcode: no source registers.
- rs1 = id_inst[19:15], rs2 = id_inst[24:20].
REQ-019 SHALL define hazard_lu = state RUN AND ex_mem_read AND ex_rd != 0 AND ex_rd equals a used source register.
REQ-020 SHALL define freeze = dmem_req AND NOT dmem_ready.
REQ-021 SHALL drive the outputs combinationally from state and inputs, in this strict priority order (highest first):
- freeze: pc_write=0, ifid_write=0, idex_write=0, ifid_flush=0, idex_bubble=0, exmem_hold=1.
- ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_write=1, idex_bubble=1, exmem_hold=0.
- hazard_lu: pc_write=0, ifid_write=0, ifid_flush=0, idex_write=1, idex_bubble=1, exmem_hold=0.
- otherwise: pc_write=1, ifid_write=1, idex_write=1, all other control outputs 0.
REQ-022 SHALL implement the FSM with states RUN, LU_STALL and MEM_WAIT, with these transitions:
- RUN -> MEM_WAIT on freeze.
- RUN -> LU_STALL on hazard_lu when neither freeze nor ex_branch_taken is asserted.
- otherwise stay in RUN.
REQ-023 SHALL leave LU_STALL after exactly one cycle: to MEM_WAIT if freeze is asserted, else to RUN; hazard_lu SHALL NOT be detected while in LU_STALL.
REQ-024 SHALL stay in MEM_WAIT while freeze is asserted and go to RUN in the first cycle freeze is deasserted; the outputs in that release cycle follow the normal REQ-021 priority.
REQ-025 SHALL clear an 8-bit wait counter on entry to MEM_WAIT and increment it every cycle spent in MEM_WAIT.
REQ-026 SHALL set mem_timeout when the wait counter reaches 255 while still in MEM_WAIT; mem_timeout stays set until rst.
REQ-027 SHALL increment stall_cnt once per cycle in which the hazard_lu outputs are driven, saturating at 0xFFFF.
REQ-028 SHALL increment flush_cnt once per cycle in which the branch-flush outputs are driven, saturating at 0xFFFF.
REQ-029 SHALL NOT let a branch held during freeze count or flush until the release cycle; EX is frozen, so ex_branch_taken is re-presented then.

Reset
REQ-030 SHALL, at a clock edge with rst high, set state=RUN and clear stall_cnt, flush_cnt, the wait counter and mem_timeout.
REQ-031 SHALL, while rst is high, drive pc_write=0, ifid_write=0, idex_write=0, ifid_flush=1, idex_bubble=1 and exmem_hold=0, overriding all other conditions.
REQ-032 SHALL abandon any stall or wait immediately when rst is asserted mid-operation; the first cycle after rst deasserts is evaluated from state RUN.

Verification
REQ-033 SHALL cover load-use: ex_mem_read=1, ex_rd=5, id_inst=add x1,x5,x2 -> one cycle with pc_write=0, idex_bubble=1, stall_cnt=1; next cycle normal (state LU_STALL).
REQ-034 SHALL cover no false hazards: ex_rd=0, or the lui opcode 0110111 in ID using x5 -> no stall; a store with rs2=ex_rd -> stall.
REQ-035 SHALL cover branch over load-use: ex_branch_taken=1 together with a load-use hazard -> ifid_flush=1, idex_bubble=1, pc_write=1, flush_cnt+1, stall_cnt unchanged.
REQ-036 SHALL cover memory wait: dmem_req=1, dmem_ready=0 for 3 cycles -> exmem_hold=1 and all write enables 0 for 3 cycles; normal operation on the 4th cycle; mem_timeout=0.
REQ-037 SHALL cover the watchdog: dmem_ready held at 0 for 300 cycles -> mem_timeout=1 from the cycle the wait counter hits 255; mem_timeout stays 1 after release until rst.
REQ-038 SHALL cover saturation and reset: force 65540 flushes -> flush_cnt=0xFFFF; assert rst for one cycle during MEM_WAIT -> counters 0, state RUN, reset output values driven.
